mux_arb_datos: RTL and testbench

Parametrised N-channel arbitrating data multiplexer with a registered valid/ready output stage and burst locking. It replaces the fixed 2:1 combinational RAM/CPU data select in the cache data path. Multiple sources (RAM fill, CPU write, future DMA) compete for one data bus. Arbitration is fixed-priority, with optional round-robin. A granted multi-beat burst keeps the bus until its last beat.

---
 rtl/mux_arb_datos.sv | 229 ++++++++++++++++++++++
 tb/tb_mux_arb_datos.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_arb_datos.sv
// mux_arb_datos: N-channel arbitrating data multiplexer with a registered
// valid/ready output stage and burst locking.
// Channel 0 is RAM fill and channel 1 is CPU. Further channels can be added.
// IDLE arbitration is fixed priority, where the lowest index wins.
// Optional build macro MUX_ROUND_ROBIN_EN switches IDLE arbitration to
// round-robin. The search then starts after the channel that last completed.
// A multi-beat burst holds the bus until its last beat or until MaxBurst beats.
// A burst cut at MaxBurst gets out_last forced and sets sticky burst_err.
module mux_arb_datos #(
  parameter int SizeDataMux = 64,
  parameter int NumCanales  = 2,
  parameter int MaxBurst    = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NumCanales*SizeDataMux-1:0]                     in_data,
  input  logic [NumCanales-1:0]                                 in_valid,
  input  logic [NumCanales-1:0]                                 in_last,
  output logic [NumCanales-1:0]                                 in_ready,
  output logic [SizeDataMux-1:0]                                out_data,
  output logic [((NumCanales > 1) ? $clog2(NumCanales) : 1)-1:0] out_canal,
  output logic                                                  out_last,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic                                                  burst_err
);

  localparam int CanalW = (NumCanales > 1) ? $clog2(NumCanales) : 1;
  localparam int CntW   = $clog2(MaxBurst + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [CanalW-1:0]       lock_q, lock_d;
  logic [SizeDataMux-1:0]  out_data_q, out_data_d;
  logic [CanalW-1:0]       out_canal_q, out_canal_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic                    burst_err_q, burst_err_d;

  logic [SizeDataMux-1:0]  ch_data [NumCanales];
  logic                    arb_vld;
  logic [CanalW-1:0]       arb_idx;
  logic                    gnt_vld;
  logic [CanalW-1:0]       gnt_idx;
  logic                    gnt_last;
  logic                    can_load;
  logic                    xfer;
  logic                    hit_limit;
  logic                    burst_done;

  // Split the flattened input bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NumCanales; i++) begin
      ch_data[i] = in_data[i*SizeDataMux +: SizeDataMux];
    end
  end

`ifdef MUX_ROUND_ROBIN_EN
  logic [CanalW-1:0] rr_q, rr_d;
  logic              hi_vld;
  logic [CanalW-1:0] hi_idx;
  logic [CanalW-1:0] lo_idx;

  // Round-robin pick: the first valid channel above the pointer, else wrap to the lowest valid channel.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = {CanalW{1'b0}};
    lo_idx  = {CanalW{1'b0}};
    arb_vld = |in_valid;
    for (int i = NumCanales - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = CanalW'(i);
        if (CanalW'(i) > rr_q) begin
          hi_vld = 1'b1;
          hi_idx = CanalW'(i);
        end else begin
          hi_vld = hi_vld;
        end
      end else begin
        lo_idx = lo_idx;
      end
    end
    if (hi_vld) begin
      arb_idx = hi_idx;
    end else begin
      arb_idx = lo_idx;
    end
  end

  // The pointer advances only when a single beat or a whole burst completes.
  always_comb begin
    if (burst_done) begin
      rr_d = gnt_idx;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= {CanalW{1'b0}};
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: the lowest-index valid channel wins.
  always_comb begin
    arb_vld = |in_valid;
    arb_idx = {CanalW{1'b0}};
    for (int i = NumCanales - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        arb_idx = CanalW'(i);
      end else begin
        arb_idx = arb_idx;
      end
    end
  end
`endif

  // Grant, handshake, output-stage load and burst FSM next state.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    lock_d      = lock_q;
    out_data_d  = out_data_q;
    out_canal_d = out_canal_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    burst_err_d = burst_err_q;
    in_ready    = {NumCanales{1'b0}};

    can_load = !out_valid_q || out_ready;

    if (state_q == ST_LOCK) begin
      gnt_idx = lock_q;
      gnt_vld = in_valid[lock_q];
    end else begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
    end
    gnt_last = in_last[gnt_idx];

    xfer       = gnt_vld && can_load && !rst;
    // This beat is number MaxBurst of a locked burst, so the burst ends here.
    hit_limit  = (state_q == ST_LOCK) && (beat_cnt_q == CntW'(MaxBurst - 1));
    burst_done = xfer && (gnt_last || hit_limit);

    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
      out_data_d        = ch_data[gnt_idx];
      out_canal_d       = gnt_idx;
      out_last_d        = gnt_last || hit_limit;
      out_valid_d       = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer && !gnt_last) begin
          state_d    = ST_LOCK;
          lock_d     = gnt_idx;
          beat_cnt_d = CntW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (burst_done) begin
          state_d    = ST_IDLE;
          beat_cnt_d = {CntW{1'b0}};
          if (!gnt_last) begin
            burst_err_d = 1'b1;
          end else begin
            burst_err_d = burst_err_q;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = {CntW{1'b0}};
      end
    endcase
  end

  // State, burst tracking and output-stage registers.
  // A synchronous reset clears them and discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= {CntW{1'b0}};
      lock_q      <= {CanalW{1'b0}};
      out_data_q  <= {SizeDataMux{1'b0}};
      out_canal_q <= {CanalW{1'b0}};
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      lock_q      <= lock_d;
      out_data_q  <= out_data_d;
      out_canal_q <= out_canal_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_canal = out_canal_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_mux_arb_datos.sv
// Directed-vector bench for mux_arb_datos (default build: fixed priority,
// 2 channels, 64-bit data, MaxBurst=8). Expected output beats go into a
// scoreboard queue; a negedge monitor pops and compares accepted beats.
module tb_mux_arb_datos;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [1:0]   in_valid;
  logic [1:0]   in_last;
  logic [1:0]   in_ready;
  logic [63:0]  out_data;
  logic [0:0]   out_canal;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         burst_err;

  int n_vec;
  int n_err;

  // Expected beat: {data[63:0], canal, last}
  logic [65:0] exp_q [$];

  mux_arb_datos #(.SizeDataMux(64), .NumCanales(2), .MaxBurst(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_canal(out_canal), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic c, input logic l);
    exp_q.push_back({d, c, l});
  endtask

  // One cycle of stimulus; entered and left at posedge+1, in_ready checked at negedge.
  task automatic step(input logic [1:0] v, input logic [1:0] l, input logic [63:0] d0,
                      input logic [63:0] d1, input logic ordy, input logic [1:0] exp_rdy);
    in_valid  = v;
    in_last   = l;
    in_data   = {d1, d0};
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", {126'd0, in_ready}, {126'd0, exp_rdy});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every beat accepted downstream is checked against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data=%0h canal=%0d last=%0d, expected no beat",
                 out_data, out_canal, out_last);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        chk("out_beat", {62'd0, out_data, out_canal, out_last}, {62'd0, e});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 2'b11; in_last = 2'b11; out_ready = 1'b1;
    in_data = {64'h20, 64'h10};
    n_vec = 0; n_err = 0;

    // Reset held 3 cycles with all channels requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {58'd0, out_data, out_canal, out_last, out_valid, burst_err, in_ready},
                      128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(64'h10, 1'b0, 1'b1);
    step(2'b11, 2'b11, 64'h10, 64'h20, 1'b1, 2'b01);
    chk("first_valid", {127'd0, out_valid}, 128'd1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);

    // Contention: ch0 always wins, ch1 starves.
    for (int k = 0; k < 4; k++) begin
      push(64'h100 + 64'(k), 1'b0, 1'b1);
      step(2'b11, 2'b11, 64'h100 + 64'(k), 64'h200 + 64'(k), 1'b1, 2'b01);
    end
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);

    // Burst lock: ch1 A0..A3; ch0 requests from cycle 2 and waits.
    push(64'hA0, 1'b1, 1'b0); step(2'b10, 2'b00, 64'h0,  64'hA0, 1'b1, 2'b10);
    push(64'hA1, 1'b1, 1'b0); step(2'b11, 2'b01, 64'hB0, 64'hA1, 1'b1, 2'b10);
    push(64'hA2, 1'b1, 1'b0); step(2'b11, 2'b01, 64'hB0, 64'hA2, 1'b1, 2'b10);
    push(64'hA3, 1'b1, 1'b1); step(2'b11, 2'b11, 64'hB0, 64'hA3, 1'b1, 2'b10);
    push(64'hB0, 1'b0, 1'b1); step(2'b01, 2'b01, 64'hB0, 64'h0,  1'b1, 2'b01);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);

    // Backpressure mid-burst.
    push(64'hC0, 1'b1, 1'b0); step(2'b10, 2'b00, 64'h0, 64'hC0, 1'b1, 2'b10);
    push(64'hC1, 1'b1, 1'b0); step(2'b10, 2'b00, 64'h0, 64'hC1, 1'b1, 2'b10);
    for (int k = 0; k < 5; k++) begin
      step(2'b10, 2'b00, 64'h0, 64'hC2, 1'b0, 2'b00);
      chk("bp_hold", {62'd0, out_data, out_canal, out_valid}, {62'd0, 64'hC1, 1'b1, 1'b1});
    end
    push(64'hC2, 1'b1, 1'b0); step(2'b10, 2'b00, 64'h0, 64'hC2, 1'b1, 2'b10);
    push(64'hC3, 1'b1, 1'b1); step(2'b10, 2'b10, 64'h0, 64'hC3, 1'b1, 2'b10);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);

    // Burst overrun: ch0 sends 10 beats without last.
    for (int k = 0; k < 10; k++) begin
      push(64'hD0 + 64'(k), 1'b0, (k == 7) ? 1'b1 : 1'b0);
      step(2'b01, 2'b00, 64'hD0 + 64'(k), 64'h0, 1'b1, 2'b01);
      if (k == 6) chk("err_before_limit", {127'd0, burst_err}, 128'd0);
      if (k == 7) chk("err_at_limit", {127'd0, burst_err}, 128'd1);
    end
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);
    chk("err_sticky", {127'd0, burst_err}, 128'd1);

    // Reset clears the sticky error and the unfinished ch0 burst.
    rst = 1'b1;
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);
    rst = 1'b0;
    chk("err_cleared", {126'd0, burst_err, out_valid}, 128'd0);

    // Reset during beat 3 of a locked ch1 burst.
    push(64'hE0, 1'b1, 1'b0); step(2'b10, 2'b00, 64'h0, 64'hE0, 1'b1, 2'b10);
    step(2'b10, 2'b00, 64'h0, 64'hE1, 1'b1, 2'b10);
    rst = 1'b1;
    step(2'b10, 2'b00, 64'h0, 64'hE2, 1'b1, 2'b00);
    rst = 1'b0;
    chk("rst_mid_valid", {127'd0, out_valid}, 128'd0);
    push(64'hF0, 1'b0, 1'b1); step(2'b11, 2'b01, 64'hF0, 64'hE2, 1'b1, 2'b01);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 2'b00);

    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
